// File: rtl/mac_result_drain.sv
// Runs one accumulation window on a MAC lane column, snapshots the lane results and streams them out one lane per beat.
// First beat arrives ACC_LEN+2 cycles after start is sampled; a stalled beat holds while out_ready is low, for any length.
module mac_result_drain #(
  parameter int LANES   = 8,
  parameter int BW      = 8,
  parameter int ACC_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     op_en,
  output logic                     acc_first,
  input  logic [LANES*2*BW-1:0]    lane_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*BW-1:0]          out_data,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int DW = 2 * BW;
  localparam int IW = $clog2(LANES);
  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SETTLE, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [LANES-1:0][DW-1:0] shadow_q, shadow_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    done_d    = 1'b0;
    op_en     = 1'b0;
    acc_first = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_lane  = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        op_en     = 1'b1;
        acc_first = (cnt_q == '0);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = SETTLE;
      end
      SETTLE: begin
        // The last issued operands land in the lanes exactly now.
        shadow_d = lane_res;
        idx_d    = '0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = shadow_q[idx_q];
        out_lane  = idx_q;
        out_last  = (idx_q == IDX_LAST);
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench: instance 0 runs ACC_LEN=4, instance 1 runs ACC_LEN=1; both use LANES=4, BW=8.
module tb_mac_result_drain;

  typedef struct packed {
    logic        inst;
    logic [1:0]  lane;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        start     [2];
  logic        op_en     [2];
  logic        acc_first [2];
  logic [63:0] lane_res  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic [1:0]  out_lane  [2];
  logic        out_last  [2];
  logic        busy      [2];
  logic        done      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mac_result_drain #(.LANES(4), .BW(8), .ACC_LEN(g == 0 ? 4 : 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .op_en     (op_en[g]),
      .acc_first (acc_first[g]),
      .lane_res  (lane_res[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_lane  (out_lane[g]),
      .out_last  (out_last[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MAC array model: lane i issues A=i+1, B=2; iC is zero on the window's first cycle.
  logic [3:0][15:0] acc_m [2];
  logic             ovr_en;
  logic [63:0]      ovr_vec;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (op_en[k])
        for (int i = 0; i < 4; i++)
          acc_m[k][i] <= 16'((i + 1) * 2) + (acc_first[k] ? 16'd0 : acc_m[k][i]);
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      lane_res[k] = (k == 0 && ovr_en) ? ovr_vec : acc_m[k];
  end

  beat_t exp_q [$];
  int    tests, fails, cyc;
  int    start_cyc [2];
  int    opn [2], afn [2], ndone [2];
  bit    first_pend [2], chk_gap [2], last_hs [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon();
    beat_t act;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("reset_outputs", {8'd0, op_en[k], acc_first[k], out_valid[k], out_data[k],
                              out_lane[k], out_last[k], busy[k], done[k]}, 32'd0);
        last_hs[k] = 1'b0; chk_gap[k] = 1'b0; first_pend[k] = 1'b0;
      end else begin
        chk("done_timing", {31'd0, done[k]}, {31'd0, last_hs[k]});
        last_hs[k] = 1'b0;
        if (done[k]) begin
          ndone[k]++;
          chk("op_en_count", opn[k], (k == 0) ? 4 : 1);
          chk("acc_first_count", afn[k], 1);
        end
        if (chk_gap[k]) begin
          chk("accum_follows_start", {30'd0, op_en[k], acc_first[k]}, 32'd3);
          chk_gap[k] = 1'b0;
        end
        if (acc_first[k]) chk("acc_first_position", {opn[k][30:0], op_en[k]}, 32'd1);
        if (op_en[k]) opn[k]++;
        if (acc_first[k]) afn[k]++;
        if (start[k] && !busy[k]) begin
          start_cyc[k] = cyc; first_pend[k] = 1'b1; chk_gap[k] = 1'b1;
          opn[k] = 0; afn[k] = 0;
        end
        if (out_valid[k]) begin
          if (first_pend[k]) begin
            chk("first_valid_latency", cyc - start_cyc[k], (k == 0) ? 6 : 3);
            first_pend[k] = 1'b0;
          end
          act = '{inst: 1'(k), lane: out_lane[k], data: out_data[k], last: out_last[k]};
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {12'd0, act}, 32'hFFFFFFFF);
          end else begin
            chk("beat", {12'd0, act}, {12'd0, exp_q[0]});
            if (out_ready[k]) begin
              last_hs[k] = out_last[k];
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  endtask

  task automatic push_job(input int k, input bit maxv);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.inst = 1'(k);
      b.lane = 2'(i);
      b.data = maxv ? 16'hFFFF : 16'((k == 0 ? 8 : 2) * (i + 1));
      b.last = (i == 3);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_job(input int k);
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      hit = done[k];
    end
    if (!hit) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_lane(input int k, input logic [1:0] lane);
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      hit = out_valid[k] && out_ready[k] && (out_lane[k] == lane);
    end
    if (!hit) chk("wait_lane_timeout", {30'd0, lane}, 32'hFF);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; out_ready[k] = 1'b1;
      opn[k] = 0; afn[k] = 0; ndone[k] = 0; start_cyc[k] = 0;
      first_pend[k] = 1'b0; chk_gap[k] = 1'b0; last_hs[k] = 1'b0;
    end
    ovr_en = 1'b0; ovr_vec = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic job: beats 8,16,24,32.
    push_job(0, 1'b0); start_job(0); wait_done(0);

    // Backpressure: beat 1 stalled for 3 cycles.
    push_job(0, 1'b0); start_job(0);
    wait_lane(0, 2'd0);
    @(posedge clk); #1 out_ready[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    wait_done(0);

    // Starts during ACCUM and DRAIN are ignored.
    push_job(0, 1'b0); start_job(0);
    repeat (2) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    wait_lane(0, 2'd0);
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    wait_done(0);

    // All-ones snapshot; lane_res zeroed during DRAIN must not leak through.
    ovr_vec = {64{1'b1}}; ovr_en = 1'b1;
    push_job(0, 1'b1); start_job(0);
    wait_lane(0, 2'd0);
    ovr_vec = '0;
    wait_done(0);
    ovr_en = 1'b0;

    // ACC_LEN=1, second start in the done cycle.
    push_job(1, 1'b0); start_job(1);
    wait_lane(1, 2'd3);
    push_job(1, 1'b0);
    @(posedge clk); #1 start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    wait_done(1);

    // Reset after beat 1 of a drain, then a fresh job.
    push_job(0, 1'b0); start_job(0);
    wait_lane(0, 2'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_job(0, 1'b0); start_job(0); wait_done(0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("done_total_0", ndone[0], 5);
    chk("done_total_1", ndone[1], 2);
    chk("idle_at_end", {30'd0, busy[0], busy[1]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
